sim_bus_arbiter: RTL and testbench
==================================

Name: sim_bus_arbiter

Overview:
- Round-robin arbiter that lets NUM_MASTERS bus requesters share one simulation-control slave port (ctrl/print/dump registers).
- Typical requesters: core data port, debug module, testbench backdoor.
- Uses the same req/gnt/addr/we/be/wdata/rdata protocol on both sides. Adds a per-master rvalid because the slave returns rdata one cycle after grant.
- Sits between the system interconnect decode for the sim region and the sim control slave.

Parameters:
- NUM_MASTERS, 2: number of requesters; legal range 1..8.
- IDX_W, $clog2(NUM_MASTERS) (min 1): index width; derived, not overridden.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- m_req_i  input  NUM_MASTERS  per-master request
- m_gnt_o  output  NUM_MASTERS  per-master grant; one-hot or zero
- m_addr_i  input  NUM_MASTERS*32  packed addresses; master k at [32k+31:32k]
- m_we_i  input  NUM_MASTERS  write enable
- m_be_i  input  NUM_MASTERS*4  packed byte enables
- m_wdata_i  input  NUM_MASTERS*32  packed write data
- m_rdata_o  output  NUM_MASTERS*32  packed read data
- m_rvalid_o  output  NUM_MASTERS  response valid, one cycle after that master's grant
- s_req_o  output  1  slave request
- s_gnt_i  input  1  slave grant
- s_addr_o  output  32  slave address
- s_we_o  output  1  slave write enable
- s_be_o  output  4  slave byte enables
- s_wdata_o  output  32  slave write data
- s_rdata_i  input  32  slave read data, valid the cycle after s_gnt_i

Behaviour:
- Reset values:
  - all outputs 0.
  - prio_q=0, so master 0 has highest priority after reset.
  - lock_q=0, sel_q=0, rsp_vld_q=0, rsp_idx_q=0.
- Master rules:
  - A master holds req and payload stable from assertion until it sees gnt.
  - The arbiter never drops an issued s_req_o.
- Selection, combinational, when lock_q=0:
  - Scan m_req_i starting at index prio_q, wrapping modulo NUM_MASTERS.
  - The first asserted index is sel.
  - If no request is asserted, s_req_o=0.
- Lock:
  - If s_req_o=1 and s_gnt_i=0 at a clock edge: lock_q<=1 and sel_q<=sel.
  - While lock_q=1, sel=sel_q regardless of other requests; s_* outputs stay stable.
  - lock_q clears on the edge where s_gnt_i=1.
- Slave drive: s_req_o=m_req_i[sel]. s_addr_o, s_we_o, s_be_o and s_wdata_o are muxed from master sel; zero when s_req_o=0.
- Grant: m_gnt_o[sel] = s_req_o & s_gnt_i, combinational, zero-cycle. All other m_gnt_o bits are 0.
- Handshake edge (s_req_o & s_gnt_i):
  - prio_q <= (sel+1) mod NUM_MASTERS.
  - rsp_vld_q <= 1 and rsp_idx_q <= sel.
- Otherwise rsp_vld_q<=0 and prio_q holds.
- Response cycle:
  - m_rvalid_o[rsp_idx_q] = rsp_vld_q.
  - m_rdata_o slice rsp_idx_q = s_rdata_i, combinational pass-through.
  - All other rdata slices are 0.
  - Writes also get rvalid; rdata is don't-care for writes but still passed through.
- Back-to-back: a new grant is legal in the response cycle of the previous one. Throughput is 1 transfer/cycle.
- NUM_MASTERS=1: degenerates to pass-through plus rvalid; prio_q stays 0.
- Wrap-around: prio_q after granting index NUM_MASTERS-1 is 0.
- Reset mid-operation: a pending response is dropped (no rvalid); lock and priority return to reset values.

Optional Feature:
- Macro SIM_ARB_FIXED_PRIO_EN.
- Defined:
  - Scan always starts at index 0, so the lowest index wins.
  - prio_q is not implemented.
  - Lock and response behaviour are unchanged.
- Undefined: round-robin as above.

Test Plan:
- Single master: reset, m_req_i=2'b01, addr 0x4, we=1, be=0x1, wdata=0x41, slave gnt tied to req.
  - -> m_gnt_o=2'b01 the same cycle; s_addr_o=0x4, s_wdata_o=0x41.
  - -> m_rvalid_o=2'b01 the next cycle; prio_q=1.
- Contention: both masters hold req for 6 cycles, slave always grants.
  - -> grant sequence 0,1,0,1,0,1.
  - -> each rvalid follows its grant by one cycle.
- Stall: master 1 selected, s_gnt_i=0 for 3 cycles, master 0 raises req in stall cycle 2.
  - -> s_addr_o stays master 1's value and m_gnt_o=0 during the stall.
  - -> cycle 4: m_gnt_o=2'b10; next grant goes to master 0.
- Read data routing: master 1 read granted, s_rdata_i=0xDEADBEEF in the following cycle.
  - -> m_rdata_o[63:32]=0xDEADBEEF, m_rdata_o[31:0]=0, m_rvalid_o=2'b10.
- Reset mid-op: assert rst_ni low in the cycle after a master 1 grant.
  - -> m_rvalid_o stays 0.
  - -> after release, with both masters requesting, master 0 is granted first.
- SIM_ARB_FIXED_PRIO_EN defined, both masters requesting for 4 cycles.
  - -> master 0 is granted every cycle and m_gnt_o[1] is never asserted.

Source files
------------

// File: rtl/sim_bus_arbiter.sv
// Round-robin arbiter for NUM_MASTERS requesters sharing one sim-control slave port.
// Defining SIM_ARB_FIXED_PRIO_EN makes the scan always start at master 0.
module sim_bus_arbiter #(
    parameter int NUM_MASTERS = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_MASTERS-1:0]    m_req_i,
    output logic [NUM_MASTERS-1:0]    m_gnt_o,
    input  logic [NUM_MASTERS*32-1:0] m_addr_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS*4-1:0]  m_be_i,
    input  logic [NUM_MASTERS*32-1:0] m_wdata_i,
    output logic [NUM_MASTERS*32-1:0] m_rdata_o,
    output logic [NUM_MASTERS-1:0]    m_rvalid_o,
    output logic                      s_req_o,
    input  logic                      s_gnt_i,
    output logic [31:0]               s_addr_o,
    output logic                      s_we_o,
    output logic [3:0]                s_be_o,
    output logic [31:0]               s_wdata_o,
    input  logic [31:0]               s_rdata_i
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    // Handshake: a transfer happens on the edge where s_req_o & s_gnt_i; once s_req_o
    // is raised it and the payload hold until that edge, and rdata/rvalid follow one cycle later.
    logic             lock_q;
    logic [IDX_W-1:0] sel_q;
    logic             rsp_vld_q;
    logic [IDX_W-1:0] rsp_idx_q;
    logic [IDX_W-1:0] prio;
    logic [IDX_W-1:0] scan_sel;
    logic [IDX_W-1:0] sel;
    logic             handshake;
    int unsigned      idx;

    always_comb begin
        scan_sel = prio;
        idx      = 0;
        // Walk downward so the lowest offset from prio is the one left standing.
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            idx = int'(prio) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (m_req_i[idx]) scan_sel = IDX_W'(idx);
        end
    end

    assign sel       = lock_q ? sel_q : scan_sel;
    assign s_req_o   = m_req_i[sel];
    assign handshake = s_req_o & s_gnt_i;

    always_comb begin
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        m_gnt_o   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (s_req_o && (IDX_W'(k) == sel)) begin
                s_addr_o   = m_addr_i[32*k +: 32];
                s_we_o     = m_we_i[k];
                s_be_o     = m_be_i[4*k +: 4];
                s_wdata_o  = m_wdata_i[32*k +: 32];
                m_gnt_o[k] = s_gnt_i;
            end
        end
    end

    always_comb begin
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (rsp_vld_q && (IDX_W'(k) == rsp_idx_q)) begin
                m_rvalid_o[k]         = 1'b1;
                m_rdata_o[32*k +: 32] = s_rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q    <= 1'b0;
            sel_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_idx_q <= '0;
        end else begin
            rsp_vld_q <= handshake;
            if (handshake) rsp_idx_q <= sel;
            // Freeze the choice while the slave stalls so the issued request never changes.
            if (s_req_o && !s_gnt_i) begin
                lock_q <= 1'b1;
                sel_q  <= sel;
            end else if (s_gnt_i) begin
                lock_q <= 1'b0;
            end
        end
    end

`ifdef SIM_ARB_FIXED_PRIO_EN
    assign prio = '0;
`else
    logic [IDX_W-1:0] prio_q;
    logic [IDX_W-1:0] prio_d;

    assign prio_d = (sel == IDX_W'(NUM_MASTERS - 1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= '0;
        end else if (handshake) begin
            prio_q <= prio_d;
        end
    end

    assign prio = prio_q;
`endif

endmodule

// File: tb/tb_sim_bus_arbiter.sv
// Directed bench for sim_bus_arbiter with two masters: reset, single transfer,
// contention, slave stall, read routing and mid-operation reset.
module tb_sim_bus_arbiter;

    localparam int N = 2;
`ifdef SIM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            clk_i;
    logic            rst_ni;
    logic [N-1:0]    m_req_i;
    logic [N-1:0]    m_gnt_o;
    logic [N*32-1:0] m_addr_i;
    logic [N-1:0]    m_we_i;
    logic [N*4-1:0]  m_be_i;
    logic [N*32-1:0] m_wdata_i;
    logic [N*32-1:0] m_rdata_o;
    logic [N-1:0]    m_rvalid_o;
    logic            s_req_o;
    logic            s_gnt_i;
    logic [31:0]     s_addr_o;
    logic            s_we_o;
    logic [3:0]      s_be_o;
    logic [31:0]     s_wdata_o;
    logic [31:0]     s_rdata_i;

    logic gnt_tie;
    logic gnt_man;
    int   checks;
    int   errors;

    assign s_gnt_i = gnt_tie ? s_req_o : gnt_man;

    sim_bus_arbiter #(.NUM_MASTERS(N)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .m_req_i    (m_req_i),
        .m_gnt_o    (m_gnt_o),
        .m_addr_i   (m_addr_i),
        .m_we_i     (m_we_i),
        .m_be_i     (m_be_i),
        .m_wdata_i  (m_wdata_i),
        .m_rdata_o  (m_rdata_o),
        .m_rvalid_o (m_rvalid_o),
        .s_req_o    (s_req_o),
        .s_gnt_i    (s_gnt_i),
        .s_addr_o   (s_addr_o),
        .s_we_o     (s_we_o),
        .s_be_o     (s_be_o),
        .s_wdata_o  (s_wdata_o),
        .s_rdata_i  (s_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic test_reset();
        rst_ni    = 1'b0;
        m_req_i   = '0;
        m_addr_i  = '0;
        m_we_i    = '0;
        m_be_i    = '0;
        m_wdata_i = '0;
        s_rdata_i = 32'h1234_5678;
        gnt_tie   = 1'b1;
        gnt_man   = 1'b0;
        step();
        step();
        settle();
        checks++;
        if ({m_gnt_o, m_rvalid_o, m_rdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_master_outs got gnt=%b rvalid=%b rdata=%h want 0", m_gnt_o, m_rvalid_o, m_rdata_o);
        end
        checks++;
        if ({s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_slave_outs got req=%b addr=%h we=%b be=%h wdata=%h want 0",
                     s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o);
        end
        step();
        rst_ni    = 1'b1;
        s_rdata_i = '0;
        step();
    endtask

    task automatic test_single();
        m_req_i          = 2'b01;
        m_addr_i[31:0]   = 32'h4;
        m_we_i[0]        = 1'b1;
        m_be_i[3:0]      = 4'h1;
        m_wdata_i[31:0]  = 32'h41;
        settle();
        checks++;
        if (m_gnt_o !== 2'b01) begin
            errors++;
            $display("FAIL single_gnt got %b want 01", m_gnt_o);
        end
        checks++;
        if (s_addr_o !== 32'h4 || s_wdata_o !== 32'h41 || s_we_o !== 1'b1 || s_be_o !== 4'h1) begin
            errors++;
            $display("FAIL single_payload got addr=%h wdata=%h we=%b be=%h want 4/41/1/1",
                     s_addr_o, s_wdata_o, s_we_o, s_be_o);
        end
        step();
        m_req_i = 2'b00;
        settle();
        checks++;
        if (m_rvalid_o !== 2'b01) begin
            errors++;
            $display("FAIL single_rvalid got %b want 01", m_rvalid_o);
        end
        // Priority moved to master 1: with both requesting it must win now.
        step();
        m_req_i          = 2'b11;
        m_addr_i[63:32]  = 32'h200;
        settle();
        checks++;
        if (m_gnt_o !== (FIXED ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL single_prio_next got %b want %b", m_gnt_o, FIXED ? 2'b01 : 2'b10);
        end
        step();
        m_req_i = 2'b00;
        step();
        m_addr_i[31:0] = 32'h100;
    endtask

    task automatic test_contention();
        logic [1:0] prev_g;
        logic [1:0] exp_g;
        prev_g  = 2'b00;
        m_req_i = 2'b11;
        for (int c = 0; c < 6; c++) begin
            exp_g = (FIXED || (c % 2 == 0)) ? 2'b01 : 2'b10;
            settle();
            checks++;
            if (m_gnt_o !== exp_g) begin
                errors++;
                $display("FAIL contention_gnt[%0d] got %b want %b", c, m_gnt_o, exp_g);
            end
            checks++;
            if (m_rvalid_o !== prev_g) begin
                errors++;
                $display("FAIL contention_rvalid[%0d] got %b want %b", c, m_rvalid_o, prev_g);
            end
            checks++;
            if (s_addr_o !== (exp_g == 2'b01 ? 32'h100 : 32'h200)) begin
                errors++;
                $display("FAIL contention_addr[%0d] got %h", c, s_addr_o);
            end
            prev_g = exp_g;
            step();
        end
        m_req_i = 2'b00;
        settle();
        checks++;
        if (m_rvalid_o !== prev_g) begin
            errors++;
            $display("FAIL contention_last_rvalid got %b want %b", m_rvalid_o, prev_g);
        end
        step();
    endtask

    task automatic test_stall();
        gnt_tie = 1'b0;
        gnt_man = 1'b0;
        m_req_i = 2'b10;
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) m_req_i = 2'b11;
            settle();
            checks++;
            if (m_gnt_o !== 2'b00 || s_req_o !== 1'b1 || s_addr_o !== 32'h200) begin
                errors++;
                $display("FAIL stall_hold[%0d] got gnt=%b req=%b addr=%h want 00/1/200",
                         c, m_gnt_o, s_req_o, s_addr_o);
            end
            step();
        end
        gnt_man = 1'b1;
        settle();
        checks++;
        if (m_gnt_o !== 2'b10 || s_addr_o !== 32'h200) begin
            errors++;
            $display("FAIL stall_release got gnt=%b addr=%h want 10/200", m_gnt_o, s_addr_o);
        end
        step();
        m_req_i = 2'b01;
        settle();
        checks++;
        if (m_gnt_o !== 2'b01 || m_rvalid_o !== 2'b10) begin
            errors++;
            $display("FAIL stall_next got gnt=%b rvalid=%b want 01/10", m_gnt_o, m_rvalid_o);
        end
        step();
        m_req_i = 2'b00;
        gnt_man = 1'b0;
        gnt_tie = 1'b1;
        settle();
        checks++;
        if (m_rvalid_o !== 2'b01) begin
            errors++;
            $display("FAIL stall_next_rvalid got %b want 01", m_rvalid_o);
        end
        step();
    endtask

    task automatic test_read_routing();
        m_req_i   = 2'b10;
        m_we_i[1] = 1'b0;
        settle();
        checks++;
        if (m_gnt_o !== 2'b10 || s_we_o !== 1'b0) begin
            errors++;
            $display("FAIL read_gnt got gnt=%b we=%b want 10/0", m_gnt_o, s_we_o);
        end
        step();
        m_req_i   = 2'b00;
        s_rdata_i = 32'hDEAD_BEEF;
        settle();
        checks++;
        if (m_rdata_o[63:32] !== 32'hDEAD_BEEF || m_rdata_o[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL read_rdata got %h want deadbeef_00000000", m_rdata_o);
        end
        checks++;
        if (m_rvalid_o !== 2'b10) begin
            errors++;
            $display("FAIL read_rvalid got %b want 10", m_rvalid_o);
        end
        step();
        s_rdata_i = '0;
        settle();
        checks++;
        if (m_rvalid_o !== 2'b00) begin
            errors++;
            $display("FAIL read_rvalid_drop got %b want 00", m_rvalid_o);
        end
        step();
    endtask

    task automatic reset_after_grant(input logic [1:0] who, input string tag);
        m_req_i = who;
        step();
        m_req_i = 2'b00;
        rst_ni  = 1'b0;
        settle();
        checks++;
        if (m_rvalid_o !== 2'b00) begin
            errors++;
            $display("FAIL %s_rvalid got %b want 00", tag, m_rvalid_o);
        end
        step();
        settle();
        checks++;
        if (m_rvalid_o !== 2'b00) begin
            errors++;
            $display("FAIL %s_rvalid_hold got %b want 00", tag, m_rvalid_o);
        end
        step();
        rst_ni = 1'b1;
        step();
        m_req_i = 2'b11;
        settle();
        checks++;
        if (m_gnt_o !== 2'b01) begin
            errors++;
            $display("FAIL %s_first_gnt got %b want 01", tag, m_gnt_o);
        end
        step();
        m_req_i = 2'b00;
        step();
    endtask

    task automatic test_reset_midop();
        reset_after_grant(2'b10, "rst_m1");
        // Granting master 0 leaves priority on master 1, so only reset can restore master 0.
        reset_after_grant(2'b01, "rst_m0");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_read_routing();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
